// File: rtl/m_imem_loader.sv
// m_imem_loader: byte-stream program loader that fills instruction memory and holds the core while loading
// Ports:
//   w_clk, w_rst_n            clock (rising edge), asynchronous active-low reset
//   w_start                   pulse that begins a load; ignored while w_busy=1
//   w_rx_data/valid/ready     byte stream handshake (count N, then N little-endian words)
//   w_we/w_waddr/w_wdata      one-cycle instruction-memory write per word, byte address word-aligned
//   w_busy                    load in progress (core holds its PC at 0)
//   w_done/w_err              sticky result of the last load
// Option: LOADER_CHECKSUM_EN adds a trailing checksum byte that must make the payload sum 0 mod 256.
module m_imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_start,
  input  logic [7:0]  w_rx_data,
  input  logic        w_rx_valid,
  output logic        w_rx_ready,
  output logic        w_we,
  output logic [31:0] w_waddr,
  output logic [31:0] w_wdata,
  output logic        w_busy,
  output logic        w_done,
  output logic        w_err
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR, S_CSUM} state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif
  state_t        r_state, w_state_nx;
  logic [1:0]    r_bcnt;
  logic [31:0]   r_cnt;
  logic [23:0]   r_word;
  logic [ADDR_W:0] r_widx, w_widx_nx;
  logic [31:0]   r_waddr, r_wdata, w_n;
  logic          w_acc, w_last, w_go;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;
`endif
  assign w_acc     = w_rx_valid && w_rx_ready;
  assign w_last    = w_acc && r_bcnt == 2'd3;
  assign w_go      = w_start && !w_busy;
  // full word count as it will look once the current (4th) header byte lands
  assign w_n       = {w_rx_data, r_cnt[31:8]};
  assign w_widx_nx = r_widx + (ADDR_W+1)'(1);
  assign w_waddr   = r_waddr;
  assign w_wdata   = r_wdata;
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start) w_state_nx = S_HDR;
      S_HDR:   if (w_last) w_state_nx = (w_n == 32'd0) ? S_FIN : (w_n > (32'd1 << ADDR_W)) ? S_ERR : S_DATA;
      S_DATA:  if (w_last) w_state_nx = S_WRITE;
      S_WRITE: w_state_nx = (32'(w_widx_nx) == r_cnt) ? S_FIN : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:  if (w_acc) w_state_nx = (8'(r_sum + w_rx_data) == 8'd0) ? S_DONE : S_ERR;
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    w_rx_ready = r_state inside {S_HDR, S_DATA, S_CSUM};
    w_we       = r_state == S_WRITE;
    w_busy     = r_state inside {S_HDR, S_DATA, S_WRITE, S_CSUM};
    w_done     = r_state == S_DONE;
    w_err      = r_state == S_ERR;
  end
  // bytes shift in from the top so byte 0 ends up in bits [7:0]
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_bcnt  <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_widx  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      if (w_go) begin
        r_bcnt <= '0;
        r_widx <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_sum  <= '0;
`endif
      end
      if (w_acc) begin
        r_bcnt <= r_bcnt + 2'd1;
        if (r_state == S_HDR) r_cnt <= w_n;
        if (r_state == S_DATA) begin
          r_word <= {w_rx_data, r_word[23:8]};
`ifdef LOADER_CHECKSUM_EN
          r_sum  <= r_sum + w_rx_data;
`endif
        end
        if (r_state == S_DATA && r_bcnt == 2'd3) begin
          r_wdata <= {w_rx_data, r_word};
          r_waddr <= 32'({r_widx, 2'b00});
        end
      end
      if (w_we) r_widx <= w_widx_nx;
    end
endmodule

// File: tb/tb_m_imem_loader.sv
// tb_m_imem_loader: randomized self-checking bench for m_imem_loader against a stream/write-list model
module tb_m_imem_loader;
  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
`ifdef LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic        w_clk = 0, w_rst_n = 0, w_start = 0, w_rx_valid = 0;
  logic [7:0]  w_rx_data = 0;
  logic        w_rx_ready, w_we, w_busy, w_done, w_err;
  logic [31:0] w_waddr, w_wdata;
  logic [63:0] wq[$];
  int n_checks = 0, n_errs = 0;

  m_imem_loader #(.ADDR_W(10)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_start(w_start), .w_rx_data(w_rx_data),
    .w_rx_valid(w_rx_valid), .w_rx_ready(w_rx_ready), .w_we(w_we), .w_waddr(w_waddr),
    .w_wdata(w_wdata), .w_busy(w_busy), .w_done(w_done), .w_err(w_err)
  );

  always #5 w_clk = ~w_clk;

  always @(negedge w_clk) if (w_we === 1'b1) wq.push_back({w_waddr, w_wdata});

  // reference stream: LE count, LE words, optional checksum making the payload sum 0 mod 256
  function automatic bq_t build(input wq_t w);
    bq_t s;
    logic [31:0] n;
    n = 32'(w.size());
    for (int i = 0; i < 4; i++) s.push_back(n[8*i +: 8]);
    foreach (w[i]) for (int b = 0; b < 4; b++) s.push_back(w[i][8*b +: 8]);
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] sum;
      sum = 0;
      for (int i = 4; i < s.size(); i++) sum += s[i];
      s.push_back(8'(-sum));
    end
`endif
    return s;
  endfunction

  // mode 0: always valid, 1: valid every other cycle, 2: random valid plus random w_start while busy
  task automatic run_load(input bq_t s, input int mode, input int stop_acc, output int cycles, output int acc);
    logic v, a;
    wq.delete();
    cycles = 0;
    acc = 0;
    w_start = 1;
    @(posedge w_clk); #1;
    w_start = 0;
    while (cycles < 20000) begin
      v = s.size() > 0 && (mode == 0 || (mode == 1 && cycles % 2 == 0) || (mode == 2 && $urandom_range(0, 2) != 0));
      w_rx_valid = v;
      w_rx_data = s.size() > 0 ? s[0] : 8'h00;
      w_start = mode == 2 && $urandom_range(0, 7) == 0;
      a = v && w_rx_ready;
      @(posedge w_clk); #1;
      cycles++;
      if (a) begin
        void'(s.pop_front());
        acc++;
      end
      if (!w_busy || (stop_acc > 0 && acc == stop_acc)) break;
    end
    w_rx_valid = 0;
    w_start = 0;
    n_checks++;
    if (cycles >= 20000) begin
      n_errs++;
      $display("FAIL timeout: load still busy after %0d cycles (limit 20000)", cycles);
    end
  endtask

  task automatic test_reset;
    int acc = 0;
    w_rst_n = 0;
    w_rx_valid = 1;
    w_rx_data = 8'h5A;
    repeat (3) @(posedge w_clk);
    #1 w_rst_n = 1;
    repeat (5) begin
      if (w_rx_valid && w_rx_ready) acc++;
      @(posedge w_clk); #1;
    end
    w_rx_valid = 0;
    n_checks += 8;
    if (acc !== 0)          begin n_errs++; $display("FAIL reset_accept got %0d exp 0", acc); end
    if (w_rx_ready !== 0)   begin n_errs++; $display("FAIL reset_ready got %b exp 0", w_rx_ready); end
    if (w_we !== 0)         begin n_errs++; $display("FAIL reset_we got %b exp 0", w_we); end
    if (w_waddr !== 0)      begin n_errs++; $display("FAIL reset_waddr got %h exp 0", w_waddr); end
    if (w_wdata !== 0)      begin n_errs++; $display("FAIL reset_wdata got %h exp 0", w_wdata); end
    if (w_busy !== 0)       begin n_errs++; $display("FAIL reset_busy got %b exp 0", w_busy); end
    if (w_done !== 0)       begin n_errs++; $display("FAIL reset_done got %b exp 0", w_done); end
    if (w_err !== 0)        begin n_errs++; $display("FAIL reset_err got %b exp 0", w_err); end
  endtask

  task automatic test_basic(input int mode);
    wq_t w = '{32'h0000_0013, 32'h0010_00B7};
    logic [63:0] exp[2] = '{64'h0000_0000_0000_0013, 64'h0000_0004_0010_00B7};
    int c, a;
    run_load(build(w), mode, 0, c, a);
    n_checks += 4;
    if (wq.size() != 2) begin n_errs++; $display("FAIL basic%0d_nwrites got %0d exp 2", mode, wq.size()); end
    if (w_done !== 1 || w_busy !== 0 || w_err !== 0) begin
      n_errs++; $display("FAIL basic%0d_flags got done=%b busy=%b err=%b exp 1 0 0", mode, w_done, w_busy, w_err);
    end
    if (mode == 0 && c != 14 + CS) begin n_errs++; $display("FAIL basic_cycles got %0d exp %0d", c, 14 + CS); end
    if (a != 12 + CS) begin n_errs++; $display("FAIL basic%0d_accepts got %0d exp %0d", mode, a, 12 + CS); end
    for (int i = 0; i < 2 && i < wq.size(); i++) begin
      n_checks++;
      if (wq[i] !== exp[i]) begin n_errs++; $display("FAIL basic%0d_write%0d got %h exp %h", mode, i, wq[i], exp[i]); end
    end
  endtask

  task automatic test_overflow;
    bq_t s = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    int c, a;
    run_load(s, 0, 0, c, a);
    n_checks += 4;
    if (w_err !== 1 || w_done !== 0) begin n_errs++; $display("FAIL ovf_flags got err=%b done=%b exp 1 0", w_err, w_done); end
    if (w_busy !== 0) begin n_errs++; $display("FAIL ovf_busy got %b exp 0", w_busy); end
    if (wq.size() != 0) begin n_errs++; $display("FAIL ovf_writes got %0d exp 0", wq.size()); end
    if (a != 4) begin n_errs++; $display("FAIL ovf_accepts got %0d exp 4", a); end
    test_basic(0);
  endtask

  task automatic test_reset_mid;
    wq_t w = '{32'h0000_0013, 32'h0010_00B7};
    int c, a;
    run_load(build(w), 0, 9, c, a);
    w_rst_n = 0;
    #1;
    n_checks += 6;
    if (w_rx_ready !== 0 || w_we !== 0 || w_busy !== 0) begin
      n_errs++; $display("FAIL mid_ctrl got ready=%b we=%b busy=%b exp 0 0 0", w_rx_ready, w_we, w_busy);
    end
    if (w_waddr !== 0) begin n_errs++; $display("FAIL mid_waddr got %h exp 0", w_waddr); end
    if (w_wdata !== 0) begin n_errs++; $display("FAIL mid_wdata got %h exp 0", w_wdata); end
    if (w_done !== 0 || w_err !== 0) begin n_errs++; $display("FAIL mid_flags got done=%b err=%b exp 0 0", w_done, w_err); end
    if (wq.size() != 1) begin n_errs++; $display("FAIL mid_nwrites got %0d exp 1", wq.size()); end
    if (wq.size() > 0 && wq[0] !== 64'h0000_0000_0000_0013) begin
      n_errs++; $display("FAIL mid_write0 got %h exp 0000000000000013", wq[0]);
    end
    w_rst_n = 1;
    @(posedge w_clk); #1;
  endtask

  task automatic test_random(input int iters, input int nmax, input int fixed_n);
    for (int it = 0; it < iters; it++) begin
      wq_t w;
      int n, mode, c, a;
      n = fixed_n >= 0 ? fixed_n : (it == 0 ? 0 : int'($urandom_range(1, nmax)));
      mode = fixed_n >= 0 ? 0 : int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) w.push_back($urandom());
      run_load(build(w), mode, 0, c, a);
      n_checks += 3;
      if (w_done !== 1 || w_err !== 0) begin n_errs++; $display("FAIL rand_flags n=%0d got done=%b err=%b exp 1 0", n, w_done, w_err); end
      if (wq.size() != n) begin n_errs++; $display("FAIL rand_nwrites got %0d exp %0d", wq.size(), n); end
      if (a != 4 + 4 * n + CS) begin n_errs++; $display("FAIL rand_accepts n=%0d got %0d exp %0d", n, a, 4 + 4 * n + CS); end
      if (mode == 0) begin
        n_checks++;
        if (c != 4 + 5 * n + CS) begin n_errs++; $display("FAIL rand_cycles n=%0d got %0d exp %0d", n, c, 4 + 5 * n + CS); end
      end
      for (int i = 0; i < n && i < wq.size(); i++) begin
        n_checks++;
        if (wq[i] !== {32'(i * 4), w[i]}) begin n_errs++; $display("FAIL rand_write%0d got %h exp %h", i, wq[i], {32'(i * 4), w[i]}); end
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int c, a;
    for (int k = 0; k < 2; k++) begin
      bq_t s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED};
      if (k == 1) s[8] = 8'hEE;
      run_load(s, 0, 0, c, a);
      n_checks += 3;
      if (w_done !== (k == 0) || w_err !== (k == 1)) begin
        n_errs++; $display("FAIL csum%0d_flags got done=%b err=%b exp %b %b", k, w_done, w_err, k == 0, k == 1);
      end
      if (wq.size() != 1) begin n_errs++; $display("FAIL csum%0d_nwrites got %0d exp 1", k, wq.size()); end
      if (wq.size() > 0 && wq[0] !== 64'h13) begin n_errs++; $display("FAIL csum%0d_write got %h exp 13", k, wq[0]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_overflow();
    test_reset_mid();
    test_random(20, 8, -1);
    test_random(1, 0, 1024);
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
